// File: rtl/bilinear_pkg.sv
// Shared constants and helpers for the bilinear scaler blocks (coordinate generator and interpolator).
package bilinear_pkg;

    localparam int FRAC_W        = 9;
    localparam int COEF_ONE      = 1 << FRAC_W;
    localparam int PIX_W         = 8;
    localparam int DST_W_DEFAULT = 256;
    localparam int DST_H_DEFAULT = 256;
    localparam int SRC_MAX       = 255;

    function automatic int addr_width(input int side);
        return $clog2(side * side);
    endfunction

    localparam int ADDR_W_DEFAULT = addr_width(SRC_MAX);

    // Clamp an integer coordinate (possibly one past the edge) to the last valid source index.
    function automatic logic [PIX_W-1:0] clamp_coord(input logic [10:0] c, input logic [PIX_W-1:0] lim);
        return (c > 11'(lim)) ? lim : c[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/bilinear_lerp.sv
// One weighted two-tap blend a*ca + b*cb, computed modulo 2^O_W and registered.
module bilinear_lerp #(
    parameter int A_W = 8,
    parameter int C_W = 10,
    parameter int O_W = 18
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [A_W-1:0] a,
    input  logic [A_W-1:0] b,
    input  logic [C_W-1:0] ca,
    input  logic [C_W-1:0] cb,
    output logic [O_W-1:0] y
);

    logic [O_W-1:0] sum;

    always_comb begin
        sum = O_W'(a) * O_W'(ca) + O_W'(b) * O_W'(cb);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y <= '0;
        end else begin
            y <= sum;
        end
    end

endmodule

// File: rtl/bilinear_interp.sv
// Bilinear interpolator: 4-tap RAM fetch, horizontal then vertical blend, saturation, destination tagging.
// Define BILINEAR_ROUND_EN for round-half-up on the final shift (truncation otherwise).
module bilinear_interp
    import bilinear_pkg::*;
#(
    parameter int DST_W  = bilinear_pkg::DST_W_DEFAULT,
    parameter int DST_H  = bilinear_pkg::DST_H_DEFAULT,
    parameter int ADDR_W = bilinear_pkg::ADDR_W_DEFAULT,
    parameter int FRAC_W = bilinear_pkg::FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [7:0]        src_width,
    input  logic [9:0]        coordinate_x,
    input  logic [9:0]        coordinate_y,
    input  logic [9:0]        coefficient1,
    input  logic [9:0]        coefficient2,
    input  logic [9:0]        coefficient3,
    input  logic [9:0]        coefficient4,
    output logic [ADDR_W-1:0] rd_addr00,
    output logic [ADDR_W-1:0] rd_addr01,
    output logic [ADDR_W-1:0] rd_addr10,
    output logic [ADDR_W-1:0] rd_addr11,
    input  logic [7:0]        rd_data00,
    input  logic [7:0]        rd_data01,
    input  logic [7:0]        rd_data10,
    input  logic [7:0]        rd_data11,
    output logic [7:0]        pix_out,
    output logic              pix_valid,
    output logic [7:0]        pix_x,
    output logic [7:0]        pix_y,
    output logic              frame_done
);

    localparam int COEF_W = FRAC_W + 1;
    localparam int H_W    = PIX_W + COEF_W;
    localparam int S_W    = H_W + COEF_W;
    localparam int SHIFT  = 2 * FRAC_W;
    localparam int R_W    = S_W + 1 - SHIFT;
    localparam logic [7:0] X_LAST = 8'(DST_W - 1);
    localparam logic [7:0] Y_LAST = 8'(DST_H - 1);

    function automatic logic [ADDR_W-1:0] row_major(input logic [7:0] y, input logic [7:0] x,
                                                     input logic [7:0] w);
        logic [16:0] a;
        a = 17'(y) * 17'(w) + 17'(x);
        return ADDR_W'(a);
    endfunction

    logic [7:0] w1, x0, x1, y0, y1;
    logic [COEF_W-1:0] c1_s1, c2_s1, c3_s1, c4_s1, c3_s2, c4_s2;
    logic v1, v2;
    logic [H_W-1:0] h0, h1;
    logic [S_W-1:0] s;
    logic [S_W:0] rsum;
    logic [R_W-1:0] r;
    logic [7:0] nx, ny;

    always_comb begin
        w1 = src_width - 8'd1;
        x0 = clamp_coord({1'b0, coordinate_x}, w1);
        x1 = clamp_coord({1'b0, coordinate_x} + 11'd1, w1);
        y0 = clamp_coord({1'b0, coordinate_y}, w1);
        y1 = clamp_coord({1'b0, coordinate_y} + 11'd1, w1);
    end

    // rd_addr* doubles as the RAM's address register, so rd_data is ready for S2 at the next edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr00 <= '0;
            rd_addr01 <= '0;
            rd_addr10 <= '0;
            rd_addr11 <= '0;
            c1_s1     <= '0;
            c2_s1     <= '0;
            c3_s1     <= '0;
            c4_s1     <= '0;
            v1        <= 1'b0;
        end else begin
            v1 <= en;
            if (en) begin
                rd_addr00 <= row_major(y0, x0, src_width);
                rd_addr01 <= row_major(y0, x1, src_width);
                rd_addr10 <= row_major(y1, x0, src_width);
                rd_addr11 <= row_major(y1, x1, src_width);
                c1_s1     <= coefficient1;
                c2_s1     <= coefficient2;
                c3_s1     <= coefficient3;
                c4_s1     <= coefficient4;
            end
        end
    end

    bilinear_lerp #(.A_W(PIX_W), .C_W(COEF_W), .O_W(H_W)) u_lerp_top (
        .clk(clk), .rst_n(rst_n), .a(rd_data00), .b(rd_data01), .ca(c1_s1), .cb(c2_s1), .y(h0)
    );

    bilinear_lerp #(.A_W(PIX_W), .C_W(COEF_W), .O_W(H_W)) u_lerp_bot (
        .clk(clk), .rst_n(rst_n), .a(rd_data10), .b(rd_data11), .ca(c1_s1), .cb(c2_s1), .y(h1)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c3_s2 <= '0;
            c4_s2 <= '0;
            v2    <= 1'b0;
        end else begin
            c3_s2 <= c3_s1;
            c4_s2 <= c4_s1;
            v2    <= v1;
        end
    end

    bilinear_lerp #(.A_W(H_W), .C_W(COEF_W), .O_W(S_W)) u_lerp_vert (
        .clk(clk), .rst_n(rst_n), .a(h0), .b(h1), .ca(c3_s2), .cb(c4_s2), .y(s)
    );

    always_comb begin
`ifdef BILINEAR_ROUND_EN
        rsum = {1'b0, s} + (S_W + 1)'(1 << (SHIFT - 1));
`else
        rsum = {1'b0, s};
`endif
        r       = rsum[S_W:SHIFT];
        pix_out = (r > R_W'(255)) ? 8'hFF : r[7:0];
    end

    // nx/ny hold the position the next emitted pixel will carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            frame_done <= 1'b0;
            nx         <= '0;
            ny         <= '0;
        end else begin
            pix_valid  <= v2;
            frame_done <= 1'b0;
            if (v2) begin
                pix_x      <= nx;
                pix_y      <= ny;
                frame_done <= (nx == X_LAST) && (ny == Y_LAST);
                if (nx == X_LAST) begin
                    nx <= '0;
                    ny <= (ny == Y_LAST) ? 8'd0 : ny + 8'd1;
                end else begin
                    nx <= nx + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bilinear_interp.sv
// Scoreboard bench for bilinear_interp: directed vectors queue hand-computed pixels, a monitor pops and compares.
module tb_bilinear_interp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  src_width;
    logic [9:0]  coordinate_x, coordinate_y;
    logic [9:0]  coefficient1, coefficient2, coefficient3, coefficient4;
    logic [15:0] rd_addr00, rd_addr01, rd_addr10, rd_addr11;
    logic [7:0]  rd_data00, rd_data01, rd_data10, rd_data11;
    logic [7:0]  pix_out, pix_x, pix_y;
    logic        pix_valid, frame_done;

    logic [7:0]  mem [0:65535];

    typedef struct {
        int pix;
        int x;
        int y;
        int fd;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ex = 0;
    int ey = 0;
    int fd_count = 0;

`ifdef BILINEAR_ROUND_EN
    localparam int HALF_PIX = 139;
`else
    localparam int HALF_PIX = 138;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // The address register lives in the DUT, so the RAM data is a plain lookup of it.
    assign rd_data00 = mem[rd_addr00];
    assign rd_data01 = mem[rd_addr01];
    assign rd_data10 = mem[rd_addr10];
    assign rd_data11 = mem[rd_addr11];

    bilinear_interp dut (
        .clk(clk), .rst_n(rst_n), .en(en), .src_width(src_width),
        .coordinate_x(coordinate_x), .coordinate_y(coordinate_y),
        .coefficient1(coefficient1), .coefficient2(coefficient2),
        .coefficient3(coefficient3), .coefficient4(coefficient4),
        .rd_addr00(rd_addr00), .rd_addr01(rd_addr01), .rd_addr10(rd_addr10), .rd_addr11(rd_addr11),
        .rd_data00(rd_data00), .rd_data01(rd_data01), .rd_data10(rd_data10), .rd_data11(rd_data11),
        .pix_out(pix_out), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .frame_done(frame_done)
    );

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int cx, input int cy, input int c1, input int c2,
                                 input int c3, input int c4, input int sw, input int pix);
        exp_t e;
        @(negedge clk);
        en           = 1'b1;
        src_width    = 8'(sw);
        coordinate_x = 10'(cx);
        coordinate_y = 10'(cy);
        coefficient1 = 10'(c1);
        coefficient2 = 10'(c2);
        coefficient3 = 10'(c3);
        coefficient4 = 10'(c4);
        e.pix = pix;
        e.x   = ex;
        e.y   = ey;
        e.fd  = (ex == 255 && ey == 255) ? 1 : 0;
        e.cyc = cyc;
        sb.push_back(e);
        if (ex == 255) begin
            ex = 0;
            ey = (ey == 255) ? 0 : ey + 1;
        end else begin
            ex = ex + 1;
        end
    endtask

    task automatic idleCheckAddr(input string tag, input int a00, input int a01, input int a10, input int a11);
        @(negedge clk);
        en = 1'b0;
        checkOutput({tag, "_addr00"}, rd_addr00, a00);
        checkOutput({tag, "_addr01"}, rd_addr01, a01);
        checkOutput({tag, "_addr10"}, rd_addr10, a10);
        checkOutput({tag, "_addr11"}, rd_addr11, a11);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en = 1'b0;
        end
    endtask

    // Monitor: every presented pixel must match the oldest queued expectation, exactly 3 edges after issue.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && frame_done === 1'b1) fd_count++;
        if (rst_n === 1'b1 && pix_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_pix", pix_valid, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("pix_out", pix_out, e.pix);
                checkOutput("pix_x", pix_x, e.x);
                checkOutput("pix_y", pix_y, e.y);
                checkOutput("frame_done", frame_done, e.fd);
                checkOutput("latency", cyc, e.cyc + 3);
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'd100;
        mem[503]  = 8'd0;
        mem[504]  = 8'd100;
        mem[603]  = 8'd200;
        mem[604]  = 8'd255;
        mem[9999] = 8'd77;

        rst_n = 1'b0;
        en = 1'b0;
        src_width = 8'd100;
        coordinate_x = '0;
        coordinate_y = '0;
        coefficient1 = '0;
        coefficient2 = '0;
        coefficient3 = '0;
        coefficient4 = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_pix_out", pix_out, 0);
        checkOutput("rst_pix_valid", pix_valid, 0);
        checkOutput("rst_pix_x", pix_x, 0);
        checkOutput("rst_pix_y", pix_y, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_addr00", rd_addr00, 0);
        rst_n = 1'b1;

        applyStimulus(10, 10, 300, 212, 100, 412, 100, 100);
        idleCheckAddr("flat", 1010, 1011, 1110, 1111);
        applyStimulus(10, 10, 0, 512, 512, 0, 100, 100);
        applyStimulus(10, 10, 511, 1, 1, 511, 100, 100);
        idle(2);
        applyStimulus(3, 5, 256, 256, 256, 256, 100, HALF_PIX);
        idleCheckAddr("mid", 503, 504, 603, 604);
        applyStimulus(3, 5, 512, 0, 512, 0, 100, 0);
        applyStimulus(3, 5, 0, 512, 0, 512, 100, 255);
        applyStimulus(3, 5, 0, 512, 512, 0, 100, 100);
        applyStimulus(99, 99, 256, 256, 256, 256, 100, 77);
        idleCheckAddr("clamp", 9999, 9999, 9999, 9999);
        applyStimulus(4, 6, 1023, 0, 1023, 0, 100, 255);
        idle(6);
        checkOutput("directed_drain", sb.size(), 0);

        // Two pixels in flight when reset hits: both must vanish and tagging restarts at (0,0).
        applyStimulus(10, 10, 256, 256, 256, 256, 100, 100);
        applyStimulus(10, 10, 256, 256, 256, 256, 100, 100);
        @(negedge clk);
        en = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        ex = 0;
        ey = 0;
        @(negedge clk);
        checkOutput("rst_flight_valid", pix_valid, 0);
        rst_n = 1'b1;
        idle(4);
        checkOutput("rst_flight_valid_after", pix_valid, 0);

        fd_count = 0;
        for (int i = 0; i < 65536; i++) begin
            applyStimulus(10, 10, 256, 256, 256, 256, 100, 100);
        end
        applyStimulus(10, 10, 256, 256, 256, 256, 100, 100);
        idle(6);
        checkOutput("frame_done_pulses", fd_count, 1);
        checkOutput("wrap_pix_x", pix_x, 0);
        checkOutput("wrap_pix_y", pix_y, 0);
        checkOutput("final_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
